// File: rtl/otsu_min_select.sv
// Streaming minimum-variance threshold search for the Otsu pipeline.
// Optional index checker enabled by defining OTSU_SEL_SEQCHK_EN.
module otsu_min_select #(
  parameter int SW    = 33,
  parameter int TW    = 8,
  parameter int NBINS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [TW-1:0] in_thr,
  input  logic [SW-1:0] in_sigmaW,
  input  logic          in_last,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [TW-1:0] res_thr,
  output logic [SW-1:0] res_sigmaW,
  output logic [TW:0]   res_count,
  output logic          seq_err,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [TW:0] CNT_MAX = (TW+1)'(NBINS - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] min_q, min_d;
  logic [TW-1:0] best_q, best_d;
  logic [TW:0]   cnt_q, cnt_d;
  logic          acc;
  logic          take;
  logic          clr;

  assign acc  = in_valid && (state_q == SCAN);
  assign take = (cnt_q == '0) || (in_sigmaW < min_q);
  assign clr  = start && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    best_d  = best_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          min_d   = '1;
          best_d  = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (acc) begin
          cnt_d = cnt_q + 1'b1;
          if (take) begin
            min_d  = in_sigmaW;
            best_d = in_thr;
          end
          if (in_last || cnt_q == CNT_MAX)
            state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      min_q   <= '1;
      best_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      best_q  <= best_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef OTSU_SEL_SEQCHK_EN
  logic seq_q, seq_d;

  always_comb begin
    seq_d = seq_q;
    if (clr)
      seq_d = 1'b0;
    else if (acc && in_thr != cnt_q[TW-1:0])
      seq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seq_q <= 1'b0;
    else
      seq_q <= seq_d;
  end

  assign seq_err = seq_q;
`else
  assign seq_err = 1'b0;
`endif

  assign in_ready   = (state_q == SCAN);
  assign res_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign res_thr    = best_q;
  assign res_sigmaW = min_q;
  assign res_count  = cnt_q;

endmodule

// File: tb/tb_otsu_min_select.sv
// Scoreboarded directed bench for otsu_min_select.
module tb_otsu_min_select;

  localparam int SW = 33;
  localparam int TW = 8;
  localparam int NBINS = 256;

  typedef struct {
    logic [TW-1:0] thr;
    logic [SW-1:0] sig;
    logic [TW:0]   cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_thr;
  logic [SW-1:0] in_sigmaW;
  logic          in_last;
  logic          res_valid;
  logic          res_ready;
  logic [TW-1:0] res_thr;
  logic [SW-1:0] res_sigmaW;
  logic [TW:0]   res_count;
  logic          seq_err;
  logic          busy;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic seq_exp;

  otsu_min_select #(.SW(SW), .TW(TW), .NBINS(NBINS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_thr(in_thr), .in_sigmaW(in_sigmaW),
    .in_last(in_last), .res_valid(res_valid),
    .res_ready(res_ready), .res_thr(res_thr),
    .res_sigmaW(res_sigmaW), .res_count(res_count),
    .seq_err(seq_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int thr, input longint sig,
                      input logic last);
    in_valid  = 1'b1;
    in_thr    = TW'(thr);
    in_sigmaW = SW'(sig);
    in_last   = last;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input int thr, input longint sig,
                      input int cnt);
    exp_t e;
    e.thr = TW'(thr);
    e.sig = SW'(sig);
    e.cnt = (TW+1)'(cnt);
    q.push_back(e);
  endtask

  task automatic wait_res(input string nm);
    int n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: timeout waiting res_valid", nm);
    end
  endtask

  // Monitor: every result handshake is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_empty: got result thr %0d want none",
                   res_thr);
        end else begin
          e = q.pop_front();
          chk("sb_thr", 64'(res_thr), 64'(e.thr));
          chk("sb_sig", 64'(res_sigmaW), 64'(e.sig));
          chk("sb_cnt", 64'(res_count), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
`ifdef OTSU_SEL_SEQCHK_EN
    seq_exp = 1'b1;
`else
    seq_exp = 1'b0;
`endif
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_thr = '0; in_sigmaW = '0; in_last = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("rst_ready", 64'(in_ready), 0);
    chk("rst_rvalid", 64'(res_valid), 0);
    chk("rst_thr", 64'(res_thr), 0);
    chk("rst_sig", 64'(res_sigmaW), 64'h1_FFFF_FFFF);
    chk("rst_cnt", 64'(res_count), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_seq", 64'(seq_err), 0);
    rst_n = 1'b1;
    tick();

    // Basic scan
    push(2, 300, 5);
    go();
    chk("start_ready", 64'(in_ready), 1);
    feed(0, 900, 0);
    feed(1, 500, 0);
    feed(2, 300, 0);
    feed(3, 700, 0);
    feed(4, 800, 1);
    chk("basic_lat", 64'(res_valid), 1);
    tick();
    chk("basic_idle", 64'(busy), 0);

    // Tie and backpressure
    res_ready = 1'b0;
    push(1, 200, 4);
    go();
    feed(0, 400, 0);
    feed(1, 200, 0);
    feed(2, 200, 0);
    feed(3, 350, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(res_valid), 1);
      chk("bp_thr", 64'(res_thr), 1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("bp_idle", 64'(res_valid), 0);

    // Full scan without in_last
    push(200, 17, 256);
    go();
    for (int i = 0; i < NBINS; i++)
      feed(i, (i == 200) ? 17 : 1000 + i, 0);
    chk("full_ready", 64'(in_ready), 0);
    chk("full_valid", 64'(res_valid), 1);
    tick();

    // Gaps, start in SCAN, in_valid in IDLE
    push(1, 40, 3);
    go();
    feed(0, 50, 0);
    tick();
    go();
    feed(1, 40, 0);
    tick();
    feed(2, 60, 1);
    wait_res("gap");
    tick();
    feed(9, 1, 0);
    feed(9, 1, 1);
    chk("idle_ready", 64'(in_ready), 0);
    chk("idle_cnt", 64'(res_count), 3);

    // Reset mid-scan
    go();
    feed(0, 30, 0);
    feed(1, 20, 0);
    feed(2, 10, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 0);
    chk("mid_ready", 64'(in_ready), 0);
    chk("mid_sig", 64'(res_sigmaW), 64'h1_FFFF_FFFF);
    chk("mid_cnt", 64'(res_count), 0);
    chk("mid_thr", 64'(res_thr), 0);
    tick();
    rst_n = 1'b1;
    tick();
    // start coincident with in_valid: beat must be dropped
    push(1, 3, 2);
    start = 1'b1;
    in_valid = 1'b1;
    in_thr = '0;
    in_sigmaW = 1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    feed(0, 5, 0);
    feed(1, 3, 1);
    wait_res("rst_scan");
    tick();

    // Sequence check
    push(0, 10, 4);
    res_ready = 1'b0;
    go();
    feed(0, 10, 0);
    feed(1, 20, 0);
    chk("seq_ok", 64'(seq_err), 0);
    feed(3, 30, 0);
    chk("seq_bad", 64'(seq_err), 64'(seq_exp));
    feed(4, 40, 1);
    chk("seq_hold", 64'(seq_err), 64'(seq_exp));
    res_ready = 1'b1;
    tick();
    chk("seq_idle", 64'(seq_err), 64'(seq_exp));
    push(0, 1, 1);
    go();
    chk("seq_clr", 64'(seq_err), 0);
    feed(0, 1, 1);
    wait_res("seq_end");
    tick();
    tick();

    chk("sb_drained", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/otsu_min_select.md
# otsu_min_select

Streaming minimum-search block for the Otsu threshold pipeline. Consumes one weighted within-class variance value (`sigmaW_sq`) per candidate threshold, as produced by the variance datapath. Tracks the smallest value seen during a scan. On the final candidate it presents the winning threshold and its variance on a held result handshake for the binarisation stage.

## Interface
Parameters:
- `SW`, 33, width of incoming `sigmaW_sq` values (unsigned)
- `TW`, 8, width of threshold index
- `NBINS`, 256, maximum number of candidates per scan (must be ≤ 2^TW)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse: begin new scan (honoured only in IDLE)
- `in_valid`  in  1  candidate beat valid
- `in_ready`  out  1  block accepts candidate beat
- `in_thr`  in  TW  threshold index of this candidate
- `in_sigmaW`  in  SW  `sigmaW_sq` for this candidate
- `in_last`  in  1  final candidate of the scan
- `res_valid`  out  1  result available
- `res_ready`  in  1  downstream consumes result
- `res_thr`  out  TW  threshold with minimum variance
- `res_sigmaW`  out  SW  minimum variance value
- `res_count`  out  TW+1  number of candidates accepted in the scan
- `seq_err`  out  1  sticky: candidate index out of sequence
- `busy`  out  1  high in SCAN or DONE

## Operation
- States: IDLE, SCAN, DONE. State register is binary-coded.
- IDLE:
  - `in_ready`=0, `res_valid`=0.
  - On `start`, clear the following, then go to SCAN: `min_q`=all ones, `best_q`=0, `cnt_q`=0, `seq_err`=0.
- SCAN:
  - `in_ready`=1. A beat is accepted when `in_valid && in_ready`.
  - Update rule: on an accepted beat, if `cnt_q==0` or `in_sigmaW < min_q` (strict unsigned compare), then `min_q`<=`in_sigmaW` and `best_q`<=`in_thr`.
  - Ties keep the earlier (lower-index) threshold.
  - `cnt_q` increments by 1 on each accepted beat.
  - Go to DONE when an accepted beat has `in_last`=1, or when it is the NBINS-th beat (`cnt_q==NBINS-1`), whichever comes first.
- DONE:
  - `res_valid`=1; `res_thr`/`res_sigmaW`/`res_count` are driven from `best_q`/`min_q`/`cnt_q` and held stable.
  - On `res_valid && res_ready`, go to IDLE.
- `start` is ignored in SCAN and DONE.
- `in_valid` is ignored outside SCAN (no acceptance, no state change).
- Arithmetic: comparison is full SW-bit unsigned; no truncation.
  - `res_count` is TW+1 bits so it can express NBINS=256.
  - `cnt_q` never wraps: the NBINS limit forces DONE first.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `res_valid`=0, `res_thr`=0, `res_sigmaW`=all ones, `res_count`=0, `seq_err`=0, `busy`=0.
- `in_ready`, `res_valid` and `busy` are decoded from the registered state only; there is no combinational path from any input.
- `start` sampled at edge E → SCAN from E; `in_ready` high in the cycle after E.
- Throughput: one candidate per cycle in SCAN.
- Latency: last beat accepted at edge N → `res_valid`=1 in the cycle after N, with final min/threshold already reflected.
- `res_ready` high while `res_valid` → IDLE at that edge. A `start` one cycle later begins the next scan; no dead cycle is required beyond IDLE.
- Reset asserted mid-scan or in DONE: immediate return to reset values; any partial result is discarded.
- `start` coincident with `in_valid` in IDLE: the beat is not accepted (`in_ready`=0 that cycle).

## Configuration
- `OTSU_SEL_SEQCHK_EN` defined: in SCAN, each accepted beat checks `in_thr == cnt_q[TW-1:0]`.
  - On mismatch, `seq_err` is set and held until the next `start` or reset.
  - The beat is still used normally for the minimum search.
- Not defined: no index checker is built; `seq_err` is tied 0.

## Test plan
- Basic scan: start; feed thr 0..4 with sigmaW {900, 500, 300, 700, 800}, last on thr 4 → `res_valid` in the cycle after the last beat; `res_thr`=2, `res_sigmaW`=300, `res_count`=5.
- Tie and backpressure:
  - Feed sigmaW {400, 200, 200, 350}.
  - Hold `res_ready`=0 for 5 cycles.
  - Required: `res_thr`=1 stable throughout; `res_valid` held; IDLE one edge after `res_ready`=1.
- Full scan without `in_last`: 256 beats, minimum 17 at thr 200 → DONE after the 256th beat; `res_count`=256, `res_thr`=200; `in_ready`=0 afterwards.
- Gaps and ignored inputs:
  - `in_valid` toggles 1/0 during SCAN → only valid beats are counted.
  - `start` pulsed in SCAN → no restart.
  - `in_valid` pulsed in IDLE → `res_count` unaffected.
- Reset mid-scan: `rst_n` low after 3 beats → all outputs return to reset values immediately. A new scan of {5, 3} then yields `res_thr`=1, `res_count`=2.
- Sequence error (macro defined): indices 0, 1, 3, 4 → `seq_err`=1 from the beat with index 3 onward, cleared by the next `start`. With the macro undefined, `seq_err` stays 0.
